// File: rtl/lsu_ctrl.sv
// Load/store unit controller: splits misaligned accesses into up to two word
// accesses, merges store bytes by read-modify-write and extends load data.
module lsu_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [2:0]       req_size,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    output logic [2:0]       mem_size,
    input  logic [31:0]      mem_rd,
    output logic [CNT_W-1:0] misalign_cnt
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d, rdata_q, rdata_d;
    logic [2:0]        size_q, size_d;
    logic              we_q, we_d, err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic f_illegal(input logic we, input logic [2:0] sz);
        return (sz == 3'b011) || (sz[2:1] == 2'b11) || (we && sz[2]);
    endfunction

    function automatic logic f_span(input logic [2:0] sz, input logic [1:0] off);
        return (sz[1:0] == 2'b01 && off == 2'b11) || (sz[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic f_inword(input logic [2:0] sz, input logic [1:0] off);
        return (sz[1:0] == 2'b01) && (off == 2'b01);
    endfunction

    function automatic logic [31:0] f_ext(input logic [2:0] sz, input logic [31:0] r);
        case (sz)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'h0, r[7:0]};
            3'b101:  return {16'h0, r[15:0]};
            default: return r;
        endcase
    endfunction

    logic [1:0]  off;
    logic        span, native;
    logic [31:0] word_a;
    logic [3:0]  bm4;
    logic [7:0]  bm8;
    logic [63:0] wmask, wd64, win;
    logic [4:0]  sh;
    logic [31:0] ld_ext;

    always_comb begin
        off    = addr_q[1:0];
        span   = f_span(size_q, off);
        native = !span && !f_inword(size_q, off);
        word_a = {addr_q[31:2], 2'b00};
        sh     = {off, 3'b000};
        case (size_q[1:0])
            2'b00:   bm4 = 4'b0001;
            2'b01:   bm4 = 4'b0011;
            default: bm4 = 4'b1111;
        endcase
        bm8 = {4'b0000, bm4} << off;
        for (int i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{bm8[i]}};
        wd64 = {32'h0, wdata_q} << sh;
        // Second access sees the buffered low word below the fresh high word
        win    = (state_q == ACC1) ? {mem_rd, buf_q} : {32'h0, mem_rd};
        ld_ext = f_ext(size_q, 32'(win >> sh));
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_a    = 32'h0;
        mem_wd   = 32'h0;
        mem_size = 3'b000;
        case (state_q)
            ACC0: begin
                mem_we   = we_q;
                mem_a    = native ? addr_q : word_a;
                mem_size = native ? {1'b0, size_q[1:0]} : 3'b010;
                if (we_q)
                    mem_wd = native ? wdata_q
                                    : (mem_rd & ~wmask[31:0]) | (wd64[31:0] & wmask[31:0]);
            end
            ACC1: begin
                mem_we   = we_q;
                mem_a    = word_a + 32'd4;
                mem_size = 3'b010;
                if (we_q)
                    mem_wd = (mem_rd & ~wmask[63:32]) | (wd64[63:32] & wmask[63:32]);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                wdata_d = req_wdata;
                size_d  = req_size;
                we_d    = req_we;
                if (f_illegal(req_we, req_size)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    state_d = ACC0;
                    if ((f_span(req_size, req_addr[1:0]) || f_inword(req_size, req_addr[1:0]))
                        && !(&cnt_q))
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACC0: begin
                if (span) begin
                    buf_d   = mem_rd;
                    state_d = ACC1;
                end else begin
                    rdata_d = we_q ? 32'h0 : ld_ext;
                    state_d = RESP;
                end
            end
            ACC1: begin
                rdata_d = we_q ? 32'h0 : ld_ext;
                state_d = RESP;
            end
            RESP: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'b000;
            we_q    <= 1'b0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressable word memory model.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [2:0]  mem_size;
    logic [15:0] misalign_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [0:63];
    logic [31:0] a_log [1:8];
    logic [2:0]  s_log [1:8];
    logic [31:0] wd_log [1:8];

    lsu_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_size(mem_size),
        .mem_rd(mem_rd), .misalign_cnt(misalign_cnt)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_size)
                3'b000:  mem[mem_a[7:2]][mem_a[1:0]*8 +: 8] <= mem_wd[7:0];
                3'b001:  mem[mem_a[7:2]][mem_a[1]*16 +: 16] <= mem_wd[15:0];
                default: mem[mem_a[7:2]] <= mem_wd;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its response, logging memory activity.
    task automatic run(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] sz, input logic hold,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwe);
        lat = 0; rd = 32'hx; er = 1'bx; nwe = 0;
        for (int i = 1; i <= 8; i++) begin
            a_log[i] = 32'hx; s_log[i] = 3'bx; wd_log[i] = 32'hx;
        end
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            if (mem_we) nwe++;
            a_log[c] = mem_a; s_log[c] = mem_size; wd_log[c] = mem_wd;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("resp_one_cycle", {31'h0, resp_valid}, 32'd0);
    endtask

    int lat, nwe;
    logic [31:0] rd;
    logic er;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 3'b000;
        #3;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_cnt", {16'h0, misalign_cnt}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("ready_after_rst", {31'h0, req_ready}, 32'd1);

        // Native store / load
        run(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, lat, rd, er, nwe);
        chk("sw_lat", lat, 2); chk("sw_nwe", nwe, 1);
        chk("sw_a", a_log[1], 32'h10); chk("sw_size", {29'h0, s_log[1]}, 32'd2);
        chk("sw_wd", wd_log[1], 32'hDEADBEEF); chk("sw_rdata", rd, 32'h0);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        run(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, lat, rd, er, nwe);
        chk("lw_lat", lat, 2); chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_nwe", nwe, 0); chk("lw_err", {31'h0, er}, 32'd0);

        // Native byte store at odd offset
        run(1'b1, 32'h13, 32'h12345677, 3'b000, 1'b0, lat, rd, er, nwe);
        chk("sb_a", a_log[1], 32'h13); chk("sb_size", {29'h0, s_log[1]}, 32'd0);
        chk("sb_mem", mem[4], 32'h77ADBEEF); chk("sb_cnt", {16'h0, misalign_cnt}, 32'd0);

        // Span load
        mem[8] <= 32'h44332211; mem[9] <= 32'h88776655;
        run(1'b0, 32'h21, 32'h0, 3'b010, 1'b0, lat, rd, er, nwe);
        chk("span_ld_lat", lat, 3); chk("span_ld_a0", a_log[1], 32'h20);
        chk("span_ld_a1", a_log[2], 32'h24); chk("span_ld_rdata", rd, 32'h55443322);
        chk("span_ld_cnt", {16'h0, misalign_cnt}, 32'd1);

        // Span store
        run(1'b1, 32'h23, 32'h0000BEEF, 3'b001, 1'b0, lat, rd, er, nwe);
        chk("span_st_lat", lat, 3); chk("span_st_nwe", nwe, 2);
        chk("span_st_size", {29'h0, s_log[1]}, 32'd2);
        chk("span_st_w0", mem[8], 32'hEF332211); chk("span_st_w1", mem[9], 32'h887766BE);
        chk("span_st_cnt", {16'h0, misalign_cnt}, 32'd2);

        // Extension
        mem[12] <= 32'h00800080;
        run(1'b0, 32'h30, 32'h0, 3'b000, 1'b0, lat, rd, er, nwe);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        run(1'b0, 32'h30, 32'h0, 3'b100, 1'b0, lat, rd, er, nwe);
        chk("lbu_rdata", rd, 32'h00000080);
        run(1'b0, 32'h31, 32'h0, 3'b001, 1'b0, lat, rd, er, nwe);
        chk("lh_inword_lat", lat, 2); chk("lh_inword_rdata", rd, 32'hFFFF8000);
        run(1'b0, 32'h31, 32'h0, 3'b101, 1'b0, lat, rd, er, nwe);
        chk("lhu_inword_rdata", rd, 32'h00008000);
        chk("ext_cnt", {16'h0, misalign_cnt}, 32'd4);

        // Illegal sizes
        run(1'b1, 32'h10, 32'h55555555, 3'b100, 1'b0, lat, rd, er, nwe);
        chk("ill_st_lat", lat, 1); chk("ill_st_err", {31'h0, er}, 32'd1);
        chk("ill_st_nwe", nwe, 0); chk("ill_st_rdata", rd, 32'h0);
        chk("ill_st_mem", mem[4], 32'h77ADBEEF);
        run(1'b0, 32'h10, 32'h0, 3'b011, 1'b0, lat, rd, er, nwe);
        chk("ill_ld_err", {31'h0, er}, 32'd1); chk("ill_cnt", {16'h0, misalign_cnt}, 32'd4);

        // Address wrap
        mem[63] <= 32'hAABBCCDD; mem[0] <= 32'h11223344;
        run(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010, 1'b0, lat, rd, er, nwe);
        chk("wrap_a0", a_log[1], 32'hFFFFFFFC); chk("wrap_a1", a_log[2], 32'h0);
        chk("wrap_rdata", rd, 32'h3344AABB); chk("wrap_cnt", {16'h0, misalign_cnt}, 32'd5);

        // Reset during the second access of a span store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h22;
        req_wdata = 32'hCAFEF00D; req_size = 3'b010;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_acc1_a", mem_a, 32'h24);
        rst_n = 1'b0; #1;
        chk("mid_rst_we", {31'h0, mem_we}, 32'd0);
        chk("mid_rst_a", mem_a, 32'h0);
        chk("mid_rst_wd", mem_wd, 32'h0);
        chk("mid_rst_size", {29'h0, mem_size}, 32'd0);
        chk("mid_rst_resp", {31'h0, resp_valid}, 32'd0);
        chk("mid_rst_cnt", {16'h0, misalign_cnt}, 32'd0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        chk("mid_rst_w0", mem[8], 32'hF00D2211);
        chk("mid_rst_w1", mem[9], 32'h887766BE);
        run(1'b0, 32'h24, 32'h0, 3'b010, 1'b0, lat, rd, er, nwe);
        chk("post_rst_lat", lat, 2); chk("post_rst_rdata", rd, 32'h887766BE);
        chk("post_rst_cnt", {16'h0, misalign_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of misaligned-access counter.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; bytes taken from LSBs
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal size, valid with resp_valid
- mem_we  out  1  memory write enable
- mem_a  out  32  memory byte address
- mem_wd  out  32  memory write data
- mem_size  out  3  000 SB, 001 SH, 010 SW
- mem_rd  in  32  memory word at mem_a[31:2]; combinational read, write at clk edge
- misalign_cnt  out  CNT_W  saturating count of accepted misaligned requests

Function
REQ-003 SHALL use states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-004 SHALL latch addr, wdata, size and we on acceptance.
REQ-005 SHALL classify each request:
- native: B any offset; H with a[0]=0; W with a[1:0]=00
- inword: H with a[1:0]=01
- span: H with a[1:0]=11; W with a[1:0]!=00
REQ-006 SHALL treat store size 100/101 and any size 011/110/111 as illegal: IDLE->RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-007 SHALL follow these transitions:
- native/inword: IDLE->ACC0->RESP->IDLE
- span: IDLE->ACC0->ACC1->RESP->IDLE
REQ-008 SHALL assert mem_we only in ACC0/ACC1 and only for stores; mem_we=0 in IDLE and RESP.
REQ-009 SHALL drive the memory for a native store as: mem_a=addr, mem_size=req_size[1:0] zero-extended, mem_wd=wdata.
REQ-010 SHALL drive the memory for an inword or span store as read-modify-write of the full word:
- mem_size=010
- mem_wd = mem_rd sampled in the same cycle, with the target bytes replaced, little-endian
REQ-011 SHALL address ACC0 at {addr[31:2],2'b00} and ACC1 at {addr[31:2],2'b00}+4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-012 SHALL build load data little-endian:
- ACC0 low-word bytes are captured into a buffer
- ACC1 supplies the upper bytes
REQ-013 SHALL extend loads: B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
REQ-014 SHALL register resp_rdata and hold it valid during RESP only; resp_valid=1 for exactly one cycle per accepted request.
REQ-015 SHALL give latency from the acceptance edge to resp_valid of 2 cycles for native/inword, 3 for span, 1 for illegal.
REQ-016 SHALL increment misalign_cnt on acceptance of inword or span requests and saturate at all-ones.
REQ-017 SHALL ignore req_valid outside IDLE; no queuing.

Reset
REQ-018 SHALL, while rst_n=0 (asynchronous), force state=IDLE, misalign_cnt=0, buffers=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, mem_size=000; req_ready=1 after release.
REQ-019 SHALL, on reset asserted mid-span, abort without further writes; an ACC0 word already written stays written.

Verification
REQ-020 SHALL cover native SW: 0x10 <= 0xDEADBEEF, then LW 0x10 -> mem_we one cycle, mem_size=010; load resp 2 cycles after accept with rdata=0xDEADBEEF.
REQ-021 SHALL cover span load: words 0x20=0x44332211, 0x24=0x88776655; LW 0x21 -> ACC0 a=0x20, ACC1 a=0x24; rdata=0x55443322 after 3 cycles; misalign_cnt=1.
REQ-022 SHALL cover span store: SH 0x23, data 0xBEEF -> 0x20 byte3=0xEF, 0x24 byte0=0xBE, all other bytes unchanged.
REQ-023 SHALL cover extension: byte 0x80 at 0x30; LB -> 0xFFFFFF80, LBU -> 0x00000080; inword LH 0x31 with bytes 0x00,0x80 -> 0xFFFF8000.
REQ-024 SHALL cover illegal and wrap: store size 100 -> resp_err=1 next cycle, no mem_we; LW 0xFFFFFFFE -> ACC1 a=0x00000000.
REQ-025 SHALL cover reset mid-span: rst_n low during ACC1 -> all outputs at reset values immediately, word 0x24 unmodified, next request served normally.
